// File: rtl/flow_fetch_if.sv
// Fetch-side bundle: flow-unit redirect, instruction-memory req/gnt/rvalid channel, fetch-queue head.
// master = the fetch unit, slave = its environment (flow unit, imem, decode).
interface flow_fetch_if;
  logic        jump;
  logic [31:0] jump_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        fq_valid;
  logic [31:0] fq_pc;
  logic [31:0] fq_pc_4;
  logic [31:0] fq_instr;
  logic        fq_ready;

  modport master (
    input  jump, jump_addr, imem_gnt, imem_rvalid, imem_rdata, fq_ready,
    output imem_req, imem_addr, fq_valid, fq_pc, fq_pc_4, fq_instr
  );

  modport slave (
    output jump, jump_addr, imem_gnt, imem_rvalid, imem_rdata, fq_ready,
    input  imem_req, imem_addr, fq_valid, fq_pc, fq_pc_4, fq_instr
  );
endinterface

// File: rtl/flow_fetch.sv
// Fetch PC generator + fetch queue; redirects flush the queue and squash in-flight responses by epoch.
// Optional macro FLOW_FETCH_BYPASS_EN: forward a matching response straight to fq_* when the queue is empty.
module flow_fetch #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          FQ_DEPTH        = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic          i_clk,
  input  logic          i_reset,
  flow_fetch_if.master  io_bus
);
  localparam int FW = $clog2(FQ_DEPTH);
  localparam int CW = $clog2(FQ_DEPTH + 1);
  localparam int TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  logic [31:0]   r_fetch_pc;
  logic          r_epoch;
  logic [OW-1:0] r_outstanding;
  logic [31:0]   r_tag_pc [MAX_OUTSTANDING];
  logic          r_tag_ep [MAX_OUTSTANDING];
  logic [TW-1:0] r_tag_wr;
  logic [TW-1:0] r_tag_rd;
  logic [31:0]   r_fq_pc    [FQ_DEPTH];
  logic [31:0]   r_fq_instr [FQ_DEPTH];
  logic [FW-1:0] r_fq_wr;
  logic [FW-1:0] r_fq_rd;
  logic [CW-1:0] r_fq_count;

  logic          w_jump;
  logic [31:0]   w_jump_tgt;
  logic          w_req;
  logic          w_grant;
  logic          w_resp;
  logic          w_accept;
  logic          w_byp;
  logic          w_byp_take;
  logic          w_push;
  logic          w_pop;
  logic          w_fq_nonempty;
  logic [31:0]   w_resp_pc;
  logic [31:0]   w_fq_pc;
  logic [31:0]   w_fq_instr;
  logic          w_fq_valid;

  function automatic logic [TW-1:0] tag_inc(input logic [TW-1:0] p);
    return (int'(p) == MAX_OUTSTANDING - 1) ? '0 : p + TW'(1);
  endfunction

  assign w_jump        = io_bus.jump;
  assign w_jump_tgt    = io_bus.jump_addr & ~32'd3;
  assign w_fq_nonempty = (r_fq_count != '0);

  // Queue slots are reserved per outstanding request, so a response always has room.
  assign w_req = i_reset & !w_jump
               & (int'(r_outstanding) < MAX_OUTSTANDING)
               & (int'(r_outstanding) + int'(r_fq_count) < FQ_DEPTH);

  assign w_grant   = w_req & io_bus.imem_gnt;
  assign w_resp    = io_bus.imem_rvalid & (r_outstanding != '0);
  assign w_resp_pc = r_tag_pc[r_tag_rd];
  assign w_accept  = w_resp & !w_jump & (r_tag_ep[r_tag_rd] == r_epoch);

`ifdef FLOW_FETCH_BYPASS_EN
  assign w_byp = w_accept & !w_fq_nonempty;
`else
  assign w_byp = 1'b0;
`endif

  assign w_byp_take = w_byp & io_bus.fq_ready;
  assign w_push     = w_accept & !w_byp_take;
  assign w_pop      = w_fq_nonempty & io_bus.fq_ready;

  always_comb begin
    w_fq_valid = w_fq_nonempty | w_byp;
    w_fq_pc    = '0;
    w_fq_instr = '0;
    if (w_fq_nonempty) begin
      w_fq_pc    = r_fq_pc[r_fq_rd];
      w_fq_instr = r_fq_instr[r_fq_rd];
    end else if (w_byp) begin
      w_fq_pc    = w_resp_pc;
      w_fq_instr = io_bus.imem_rdata;
    end
  end

  assign io_bus.imem_req  = w_req;
  assign io_bus.imem_addr = r_fetch_pc;
  assign io_bus.fq_valid  = w_fq_valid;
  assign io_bus.fq_pc     = w_fq_pc;
  assign io_bus.fq_pc_4   = w_fq_valid ? (w_fq_pc + 32'd4) : 32'd0;
  assign io_bus.fq_instr  = w_fq_instr;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_fetch_pc    <= RESET_PC;
      r_epoch       <= 1'b0;
      r_outstanding <= '0;
      r_tag_wr      <= '0;
      r_tag_rd      <= '0;
      r_fq_wr       <= '0;
      r_fq_rd       <= '0;
      r_fq_count    <= '0;
    end else begin
      if (w_jump) begin
        r_fetch_pc <= w_jump_tgt;
        r_epoch    <= ~r_epoch;
      end else if (w_grant) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
      end

      if (w_grant) r_tag_wr <= tag_inc(r_tag_wr);
      if (w_resp)  r_tag_rd <= tag_inc(r_tag_rd);
      case ({w_grant, w_resp})
        2'b10:   r_outstanding <= r_outstanding + OW'(1);
        2'b01:   r_outstanding <= r_outstanding - OW'(1);
        default: ;
      endcase

      // Tags and outstanding survive a redirect so stale responses drain through the epoch check.
      if (w_jump) begin
        r_fq_rd    <= r_fq_wr;
        r_fq_count <= '0;
      end else begin
        if (w_push) r_fq_wr <= r_fq_wr + FW'(1);
        if (w_pop)  r_fq_rd <= r_fq_rd + FW'(1);
        case ({w_push, w_pop})
          2'b10:   r_fq_count <= r_fq_count + CW'(1);
          2'b01:   r_fq_count <= r_fq_count - CW'(1);
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_grant) begin
      r_tag_pc[r_tag_wr] <= r_fetch_pc;
      r_tag_ep[r_tag_wr] <= r_epoch;
    end
    if (w_push) begin
      r_fq_pc[r_fq_wr]    <= w_resp_pc;
      r_fq_instr[r_fq_wr] <= io_bus.imem_rdata;
    end
  end
endmodule

// File: tb/tb_flow_fetch.sv
// Directed bench for flow_fetch (default build): streaming, backpressure, redirects, wrap, mid-stream reset.
module tb_flow_fetch;
  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;
  int   grants;
  int   rcnt;
  logic prev_g;
  logic g;
  logic [31:0] e;

  always #5 clk = ~clk;

  flow_fetch_if bus ();

  flow_fetch #(
    .RESET_PC       (32'h0000_0000),
    .FQ_DEPTH       (4),
    .MAX_OUTSTANDING(2)
  ) dut (
    .i_clk  (clk),
    .i_reset(rst_n),
    .io_bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h want %08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic j, input logic [31:0] ja, input logic gn, input logic rv,
                       input logic [31:0] rd, input logic rdy);
    bus.jump        = j;
    bus.jump_addr   = ja;
    bus.imem_gnt    = gn;
    bus.imem_rvalid = rv;
    bus.imem_rdata  = rd;
    bus.fq_ready    = rdy;
    #1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_req"},   32'(bus.imem_req), 32'd0);
    chk({tag, "_addr"},  bus.imem_addr,     32'd0);
    chk({tag, "_fqv"},   32'(bus.fq_valid), 32'd0);
    chk({tag, "_fqpc"},  bus.fq_pc,         32'd0);
    chk({tag, "_fqpc4"}, bus.fq_pc_4,       32'd0);
    chk({tag, "_instr"}, bus.fq_instr,      32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b1;
    drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_outputs_zero("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Streaming: gnt every cycle, response one cycle later, decode always ready.
    for (int k = 0; k < 6; k++) begin
      drive(1'b0, 32'd0, 1'b1, (k >= 1), 32'hA5A5_0000 ^ 32'(4 * (k - 1)), 1'b1);
      chk("seq_req",  32'(bus.imem_req), 32'd1);
      chk("seq_addr", bus.imem_addr,     32'(4 * k));
      if (k >= 2) begin
        e = 32'(4 * (k - 2));
        chk("seq_fqv",   32'(bus.fq_valid), 32'd1);
        chk("seq_fqpc",  bus.fq_pc,         e);
        chk("seq_fqpc4", bus.fq_pc_4,       e + 32'd4);
        chk("seq_instr", bus.fq_instr,      32'hA5A5_0000 ^ e);
      end else begin
        chk("seq_fqv_early", 32'(bus.fq_valid), 32'd0);
      end
      next_cycle();
    end

    // Backpressure: decode stalled, imem grants and answers as fast as it can.
    do_reset();
    grants = 0;
    rcnt   = 0;
    prev_g = 1'b0;
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 32'd0, 1'b1, prev_g, 32'h1000_0000 + 32'(4 * rcnt), 1'b0);
      g = bus.imem_req & bus.imem_gnt;
      if (g) grants++;
      if (prev_g) rcnt++;
      prev_g = g;
      next_cycle();
    end
    drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    chk("bp_grants", 32'(grants),        32'd4);
    chk("bp_req",    32'(bus.imem_req),  32'd0);
    chk("bp_addr",   bus.imem_addr,      32'd16);
    chk("bp_fqv",    32'(bus.fq_valid),  32'd1);
    chk("bp_fqpc",   bus.fq_pc,          32'd0);
    chk("bp_instr",  bus.fq_instr,       32'h1000_0000);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1);
      chk("drain_fqv",   32'(bus.fq_valid), 32'd1);
      chk("drain_fqpc",  bus.fq_pc,         32'(4 * i));
      chk("drain_instr", bus.fq_instr,      32'h1000_0000 + 32'(4 * i));
      chk("drain_addr",  bus.imem_addr,     32'd16);
      next_cycle();
    end
    drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    chk("drain_empty", 32'(bus.fq_valid), 32'd0);
    chk("drain_req",   32'(bus.imem_req), 32'd1);

    // Redirect with two requests in flight: both stale responses must be dropped.
    do_reset();
    drive(1'b1, 32'h0000_0010, 1'b0, 1'b0, 32'd0, 1'b0);
    chk("j1_req", 32'(bus.imem_req), 32'd0);
    next_cycle();
    drive(1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0);
    chk("j1_addr10", bus.imem_addr, 32'h0000_0010);
    chk("j1_req10",  32'(bus.imem_req), 32'd1);
    next_cycle();
    drive(1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0);
    chk("j1_addr14", bus.imem_addr, 32'h0000_0014);
    next_cycle();
    drive(1'b1, 32'h0000_0103, 1'b1, 1'b0, 32'd0, 1'b0);
    chk("j2_req", 32'(bus.imem_req), 32'd0);
    next_cycle();
    drive(1'b0, 32'd0, 1'b0, 1'b1, 32'hDEAD_0010, 1'b0);
    chk("j2_req_full", 32'(bus.imem_req), 32'd0);
    chk("j2_addr",     bus.imem_addr,     32'h0000_0100);
    next_cycle();
    drive(1'b0, 32'd0, 1'b1, 1'b1, 32'hDEAD_0014, 1'b0);
    chk("j2_req_new", 32'(bus.imem_req), 32'd1);
    chk("j2_addr2",   bus.imem_addr,     32'h0000_0100);
    chk("j2_stale1",  32'(bus.fq_valid), 32'd0);
    next_cycle();
    drive(1'b0, 32'd0, 1'b0, 1'b1, 32'hCAFE_0100, 1'b0);
    chk("j2_stale2", 32'(bus.fq_valid), 32'd0);
    chk("j2_addr3",  bus.imem_addr,     32'h0000_0104);
    next_cycle();
    drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    chk("j2_fqv",   32'(bus.fq_valid), 32'd1);
    chk("j2_fqpc",  bus.fq_pc,         32'h0000_0100);
    chk("j2_fqpc4", bus.fq_pc_4,       32'h0000_0104);
    chk("j2_instr", bus.fq_instr,      32'hCAFE_0100);

    // Redirect colliding with a response and a pop.
    do_reset();
    drive(1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0);
    next_cycle();
    drive(1'b0, 32'd0, 1'b1, 1'b1, 32'hBEEF_0000, 1'b0);
    next_cycle();
    drive(1'b1, 32'h0000_0200, 1'b1, 1'b1, 32'hBEEF_0004, 1'b1);
    chk("jc_req",  32'(bus.imem_req), 32'd0);
    chk("jc_fqv",  32'(bus.fq_valid), 32'd1);
    chk("jc_fqpc", bus.fq_pc,         32'd0);
    next_cycle();
    drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    chk("jc_empty", 32'(bus.fq_valid), 32'd0);
    chk("jc_req1",  32'(bus.imem_req), 32'd1);
    chk("jc_addr",  bus.imem_addr,     32'h0000_0200);
    next_cycle();
    drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    chk("jc_empty2", 32'(bus.fq_valid), 32'd0);

    // PC wrap at the top of the address space, with a misaligned redirect target.
    do_reset();
    drive(1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 32'd0, 1'b0);
    next_cycle();
    drive(1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0);
    chk("wr_addr", bus.imem_addr,     32'hFFFF_FFFC);
    chk("wr_req",  32'(bus.imem_req), 32'd1);
    next_cycle();
    drive(1'b0, 32'd0, 1'b0, 1'b1, 32'h0BAD_F00D, 1'b0);
    chk("wr_addr0", bus.imem_addr, 32'h0000_0000);
    next_cycle();
    drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    chk("wr_fqv",   32'(bus.fq_valid), 32'd1);
    chk("wr_fqpc",  bus.fq_pc,         32'hFFFF_FFFC);
    chk("wr_fqpc4", bus.fq_pc_4,       32'h0000_0000);
    chk("wr_instr", bus.fq_instr,      32'h0BAD_F00D);

    // Reset asserted mid-stream with two outstanding, then a stray response.
    do_reset();
    drive(1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0);
    next_cycle();
    drive(1'b0, 32'd0, 1'b1, 1'b1, 32'h5555_0000, 1'b0);
    next_cycle();
    drive(1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0);
    next_cycle();
    drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    chk("mr_fqv",  32'(bus.fq_valid), 32'd1);
    chk("mr_addr", bus.imem_addr,     32'd12);
    chk("mr_req",  32'(bus.imem_req), 32'd0);
    #1;
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("mr_rst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 32'd0, 1'b0, 1'b1, 32'h7777_7777, 1'b0);
    chk("mr_post_req",  32'(bus.imem_req), 32'd1);
    chk("mr_post_addr", bus.imem_addr,     32'd0);
    next_cycle();
    drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    chk("mr_stray_fqv", 32'(bus.fq_valid), 32'd0);
    chk("mr_stray_req", 32'(bus.imem_req), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
